// File: rtl/axi_burst_beat_sequencer.sv
// Splits one AXI-style burst into single-beat commands and collapses per-beat responses into one in-order response per burst; optional counters under BURST_BEAT_SEQ_STATS_EN.
// Latency: first beat 1 cycle after cmd handshake; collapsed response is combinational from the final beat response.
// Backpressure: cmd stalls while issuing or when the length FIFO is full; the final beat response waits on out_ready_i.

module sync_fifo #(
   parameter int Width = 8,
   parameter int Depth = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       push_vld,
   input  logic [Width-1:0]           push_dat,
   input  logic                       pop_vld,
   output logic [Width-1:0]           pop_dat,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(Depth+1)-1:0] count
);
   localparam int PtrW = $clog2(Depth);
   localparam int CntW = $clog2(Depth+1);

   logic [Width-1:0] mem [Depth];
   logic [PtrW-1:0]  wr_ptr;
   logic [PtrW-1:0]  rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CntW'(Depth));
   assign empty   = (count == '0);
   assign do_push = push_vld && !full;
   assign do_pop  = pop_vld && !empty;
   assign pop_dat = mem[rd_ptr];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PtrW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PtrW'(1);
         if (do_push && !do_pop)      count <= count + CntW'(1);
         else if (!do_push && do_pop) count <= count - CntW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem[wr_ptr] <= push_dat;
   end
endmodule

module axi_burst_beat_sequencer #(
   parameter int AddrWidth = 32,
   parameter int IdWidth   = 4,
   parameter int DataWidth = 64,
   parameter int MaxTxns   = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         cmd_valid_i,
   output logic                         cmd_ready_o,
   input  logic [IdWidth-1:0]           cmd_id_i,
   input  logic [AddrWidth-1:0]         cmd_addr_i,
   input  logic [7:0]                   cmd_len_i,
   input  logic [2:0]                   cmd_size_i,
   input  logic [1:0]                   cmd_burst_i,
   output logic                         beat_valid_o,
   input  logic                         beat_ready_i,
   output logic [IdWidth-1:0]           beat_id_o,
   output logic [AddrWidth-1:0]         beat_addr_o,
   output logic                         beat_last_o,
   input  logic                         rsp_valid_i,
   output logic                         rsp_ready_o,
   input  logic                         rsp_err_i,
   output logic                         out_valid_o,
   input  logic                         out_ready_i,
   output logic                         out_err_o,
   output logic [$clog2(MaxTxns+1)-1:0] outstanding_o,
   output logic                         busy_o
`ifdef BURST_BEAT_SEQ_STATS_EN
   ,
   output logic [31:0]                  stat_beats_o,
   output logic [15:0]                  stat_errs_o
`endif
);
   localparam int MaxSize = $clog2(DataWidth/8);

   typedef enum logic {IDLE, ISSUE} state_t;
   typedef enum logic [1:0] {MODE_FIXED, MODE_INCR, MODE_WRAP} mode_t;

   state_t               state;
   mode_t                mode_q;
   mode_t                mode_d;
   logic [IdWidth-1:0]   id_q;
   logic [AddrWidth-1:0] addr_q;
   logic [AddrWidth-1:0] step;
   logic [AddrWidth-1:0] wrap_mask;
   logic [AddrWidth-1:0] incr_addr;
   logic [AddrWidth-1:0] next_addr;
   logic [7:0]           len_q;
   logic [7:0]           beat_cnt;
   logic [7:0]           rsp_cnt;
   logic [7:0]           head_len;
   logic [2:0]           size_q;
   logic [2:0]           size_sat;
   logic                 sticky;
   logic                 wrap_len_ok;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 cmd_hs;
   logic                 beat_hs;
   logic                 rsp_final;
   logic                 out_hs;

   // Burst type is resolved once at accept time so the beat loop only sees three modes.
   assign size_sat    = (cmd_size_i > 3'(MaxSize)) ? 3'(MaxSize) : cmd_size_i;
   assign wrap_len_ok = cmd_len_i inside {8'd1, 8'd3, 8'd7, 8'd15};

   always_comb begin
      case (cmd_burst_i)
         2'd1:    mode_d = MODE_INCR;
         2'd2:    mode_d = wrap_len_ok ? MODE_WRAP : MODE_INCR;
         default: mode_d = MODE_FIXED;
      endcase
   end

   assign step      = AddrWidth'(1) << size_q;
   assign wrap_mask = ((AddrWidth'(len_q) + AddrWidth'(1)) << size_q) - AddrWidth'(1);
   assign incr_addr = addr_q + step;

   always_comb begin
      case (mode_q)
         MODE_INCR: next_addr = incr_addr;
         MODE_WRAP: next_addr = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
         default:   next_addr = addr_q;
      endcase
   end

   assign cmd_ready_o  = !rst_i && (state == IDLE) && !fifo_full;
   assign cmd_hs       = cmd_valid_i && cmd_ready_o;
   assign beat_valid_o = (state == ISSUE);
   assign beat_hs      = beat_valid_o && beat_ready_i;
   assign beat_id_o    = id_q;
   assign beat_addr_o  = addr_q;
   assign beat_last_o  = beat_valid_o && (beat_cnt == len_q);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= IDLE;
         id_q     <= '0;
         addr_q   <= '0;
         len_q    <= '0;
         size_q   <= '0;
         mode_q   <= MODE_FIXED;
         beat_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_hs) begin
                  id_q     <= cmd_id_i;
                  addr_q   <= cmd_addr_i;
                  len_q    <= cmd_len_i;
                  size_q   <= size_sat;
                  mode_q   <= mode_d;
                  beat_cnt <= '0;
                  state    <= ISSUE;
               end
            end
            ISSUE: begin
               if (beat_hs) begin
                  if (beat_cnt == len_q) begin
                     state <= IDLE;
                  end else begin
                     beat_cnt <= beat_cnt + 8'd1;
                     addr_q   <= next_addr;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   sync_fifo #(
      .Width (8),
      .Depth (MaxTxns)
   ) u_len_fifo (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .push_vld (cmd_hs),
      .push_dat (cmd_len_i),
      .pop_vld  (out_hs),
      .pop_dat  (head_len),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (outstanding_o)
   );

   // Non-final beats are absorbed unconditionally; only the final one waits for the consumer.
   assign rsp_final   = (rsp_cnt == head_len);
   assign rsp_ready_o = !fifo_empty && (!rsp_final || out_ready_i);
   assign out_valid_o = !fifo_empty && rsp_final && rsp_valid_i;
   assign out_err_o   = out_valid_o && (sticky || rsp_err_i);
   assign out_hs      = out_valid_o && out_ready_i;
   assign busy_o      = (state != IDLE) || !fifo_empty;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rsp_cnt <= '0;
         sticky  <= 1'b0;
      end else if (out_hs) begin
         rsp_cnt <= '0;
         sticky  <= 1'b0;
      end else if (rsp_valid_i && rsp_ready_o) begin
         rsp_cnt <= rsp_cnt + 8'd1;
         sticky  <= sticky || rsp_err_i;
      end
   end

`ifdef BURST_BEAT_SEQ_STATS_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stat_beats_o <= '0;
         stat_errs_o  <= '0;
      end else begin
         if (beat_hs && (stat_beats_o != '1))          stat_beats_o <= stat_beats_o + 32'd1;
         if (out_hs && out_err_o && (stat_errs_o != '1)) stat_errs_o <= stat_errs_o + 16'd1;
      end
   end
`endif
endmodule
